ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage_if.sv | 42 ++++
 rtl/ex_stage.sv | 139 +++++++++++++
 tb/tb_ex_stage.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_if.sv
// ID/EX -> EX/MEM bundle for ex_stage: decoded EX-stage operands/controls in,
// registered MEM-stage result and controls out.
interface ex_stage_if;
  logic [3:0]  ex_alu_op;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic [31:0] ex_sd;
  logic [31:0] ex_pc4;
  logic [3:0]  ex_cond;
  logic        ex_store_cc;
  logic        ex_br;
  logic        ex_bl;
  logic        ex_load;
  logic        ex_mem_write;
  logic        ex_mem_enable;
  logic        ex_rf_enable;
  logic [1:0]  ex_mem_size;
  logic [3:0]  ex_rd;

  logic [31:0] mem_result;
  logic [31:0] mem_sd;
  logic [3:0]  mem_rd;
  logic        mem_load;
  logic        mem_mem_write;
  logic        mem_mem_enable;
  logic        mem_rf_enable;
  logic [1:0]  mem_mem_size;

  modport master (
    output ex_alu_op, ex_a, ex_b, ex_sd, ex_pc4, ex_cond, ex_store_cc, ex_br, ex_bl,
           ex_load, ex_mem_write, ex_mem_enable, ex_rf_enable, ex_mem_size, ex_rd,
    input  mem_result, mem_sd, mem_rd, mem_load, mem_mem_write, mem_mem_enable,
           mem_rf_enable, mem_mem_size
  );

  modport slave (
    input  ex_alu_op, ex_a, ex_b, ex_sd, ex_pc4, ex_cond, ex_store_cc, ex_br, ex_bl,
           ex_load, ex_mem_write, ex_mem_enable, ex_rf_enable, ex_mem_size, ex_rd,
    output mem_result, mem_sd, mem_rd, mem_load, mem_mem_write, mem_mem_enable,
           mem_rf_enable, mem_mem_size
  );
endinterface

// File: rtl/ex_stage.sv
// ARM-style execute stage: ALU, NZCV flags, condition check, EX/MEM register.
// Optional macro EX_COND_SQUASH_EN gates non-branch controls with cond_pass.
module ex_stage (
  input  logic       clk,
  input  logic       reset,
  input  logic       stall,
  input  logic       flush,
  ex_stage_if.slave  bus,
  output logic       branch_taken,
  output logic [3:0] flags
);

  logic [3:0]  flags_r;
  logic        n_s, z_s, c_s, v_s;
  logic        cond_pass_s;
  logic [31:0] op_x_s, op_y_s, logic_res_s, alu_res_s;
  logic        cin_s, arith_s;
  logic [32:0] sum_s;
  logic        alu_c_s, alu_v_s;
  logic [3:0]  new_flags_s;
  logic        ctl_gate_s, flags_update_s;

  logic [31:0] mem_result_r, mem_sd_r;
  logic [3:0]  mem_rd_r;
  logic [1:0]  mem_mem_size_r;
  logic        mem_load_r, mem_mem_write_r, mem_mem_enable_r, mem_rf_enable_r;

  assign {n_s, z_s, c_s, v_s} = flags_r;

  // Condition evaluation against the committed flags
  always_comb begin
    case (bus.ex_cond)
      4'h0:    cond_pass_s = z_s;
      4'h1:    cond_pass_s = ~z_s;
      4'h2:    cond_pass_s = c_s;
      4'h3:    cond_pass_s = ~c_s;
      4'h4:    cond_pass_s = n_s;
      4'h5:    cond_pass_s = ~n_s;
      4'h6:    cond_pass_s = v_s;
      4'h7:    cond_pass_s = ~v_s;
      4'h8:    cond_pass_s = c_s & ~z_s;
      4'h9:    cond_pass_s = ~c_s | z_s;
      4'hA:    cond_pass_s = (n_s == v_s);
      4'hB:    cond_pass_s = (n_s != v_s);
      4'hC:    cond_pass_s = ~z_s & (n_s == v_s);
      4'hD:    cond_pass_s = z_s | (n_s != v_s);
      4'hE:    cond_pass_s = 1'b1;
      default: cond_pass_s = 1'b0;
    endcase
  end

  // ALU operand steering: subtracts become x + ~y + carry-in on a single adder
  always_comb begin
    arith_s     = 1'b0;
    op_x_s      = bus.ex_a;
    op_y_s      = bus.ex_b;
    cin_s       = 1'b0;
    logic_res_s = 32'h0000_0000;
    case (bus.ex_alu_op)
      4'h0: logic_res_s = bus.ex_a & bus.ex_b;
      4'h1: logic_res_s = bus.ex_a ^ bus.ex_b;
      4'h2: begin arith_s = 1'b1; op_y_s = ~bus.ex_b; cin_s = 1'b1; end
      4'h3: begin arith_s = 1'b1; op_x_s = bus.ex_b; op_y_s = ~bus.ex_a; cin_s = 1'b1; end
      4'h4: arith_s = 1'b1;
      4'h5: begin arith_s = 1'b1; cin_s = c_s; end
      4'h6: begin arith_s = 1'b1; op_y_s = ~bus.ex_b; cin_s = c_s; end
      4'h7: begin arith_s = 1'b1; op_x_s = bus.ex_b; op_y_s = ~bus.ex_a; cin_s = c_s; end
      4'h8: logic_res_s = bus.ex_a | bus.ex_b;
      4'h9: logic_res_s = bus.ex_b;
      4'hA: logic_res_s = bus.ex_a & ~bus.ex_b;
      4'hB: logic_res_s = ~bus.ex_b;
      default: logic_res_s = bus.ex_a;
    endcase
  end

  assign sum_s       = {1'b0, op_x_s} + {1'b0, op_y_s} + {32'h0000_0000, cin_s};
  assign alu_res_s   = arith_s ? sum_s[31:0] : logic_res_s;
  assign alu_c_s     = arith_s ? sum_s[32] : c_s;
  assign alu_v_s     = arith_s ? ((op_x_s[31] == op_y_s[31]) && (sum_s[31] != op_x_s[31])) : v_s;
  assign new_flags_s = {alu_res_s[31], (alu_res_s == 32'h0000_0000), alu_c_s, alu_v_s};

`ifdef EX_COND_SQUASH_EN
  assign ctl_gate_s = cond_pass_s;
`else
  assign ctl_gate_s = 1'b1;
`endif

  assign flags_update_s = bus.ex_store_cc & cond_pass_s & ~stall & ~flush;
  assign branch_taken   = (bus.ex_br | bus.ex_bl) & cond_pass_s & ~flush;

  // EX/MEM register and flag state; flush outranks stall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_r          <= 4'h0;
      mem_result_r     <= 32'h0000_0000;
      mem_sd_r         <= 32'h0000_0000;
      mem_rd_r         <= 4'h0;
      mem_mem_size_r   <= 2'b00;
      mem_load_r       <= 1'b0;
      mem_mem_write_r  <= 1'b0;
      mem_mem_enable_r <= 1'b0;
      mem_rf_enable_r  <= 1'b0;
    end else begin
      if (flush) begin
        mem_result_r     <= 32'h0000_0000;
        mem_sd_r         <= 32'h0000_0000;
        mem_rd_r         <= 4'h0;
        mem_mem_size_r   <= 2'b00;
        mem_load_r       <= 1'b0;
        mem_mem_write_r  <= 1'b0;
        mem_mem_enable_r <= 1'b0;
        mem_rf_enable_r  <= 1'b0;
      end else if (!stall) begin
        mem_result_r     <= bus.ex_bl ? bus.ex_pc4 : alu_res_s;
        mem_sd_r         <= bus.ex_sd;
        mem_rd_r         <= bus.ex_bl ? 4'hE : bus.ex_rd;
        mem_mem_size_r   <= bus.ex_mem_size;
        mem_load_r       <= bus.ex_load & ctl_gate_s;
        mem_mem_write_r  <= bus.ex_mem_write & ctl_gate_s;
        mem_mem_enable_r <= bus.ex_mem_enable & ctl_gate_s;
        mem_rf_enable_r  <= bus.ex_bl ? cond_pass_s : (bus.ex_rf_enable & ctl_gate_s);
      end
      if (flags_update_s) begin
        flags_r <= new_flags_s;
      end
    end
  end

  assign flags              = flags_r;
  assign bus.mem_result     = mem_result_r;
  assign bus.mem_sd         = mem_sd_r;
  assign bus.mem_rd         = mem_rd_r;
  assign bus.mem_mem_size   = mem_mem_size_r;
  assign bus.mem_load       = mem_load_r;
  assign bus.mem_mem_write  = mem_mem_write_r;
  assign bus.mem_mem_enable = mem_mem_enable_r;
  assign bus.mem_rf_enable  = mem_rf_enable_r;

endmodule

// File: tb/tb_ex_stage.sv
// Randomized scoreboard bench for ex_stage against an arithmetic reference model.
module tb_ex_stage;

  logic       clk = 1'b0;
  logic       reset, stall, flush;
  logic       branch_taken;
  logic [3:0] flags;

  ex_stage_if bus();

  ex_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .bus(bus), .branch_taken(branch_taken), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] sd;
    logic [3:0]  rd;
    logic [1:0]  size;
    logic        load, mw, me, rf;
  } mem_t;

  mem_t       q_mem[$];
  logic [3:0] q_flags[$];
  mem_t       m_mem;
  logic [3:0] m_flags;
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string name, input logic [75:0] act, input logic [75:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic mem_t dut_mem();
    return {bus.mem_result, bus.mem_sd, bus.mem_rd, bus.mem_mem_size,
            bus.mem_load, bus.mem_mem_write, bus.mem_mem_enable, bus.mem_rf_enable};
  endfunction

  function automatic logic pass_of(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'h0: return z;             4'h1: return !z;
      4'h2: return c;             4'h3: return !c;
      4'h4: return n;             4'h5: return !n;
      4'h6: return v;             4'h7: return !v;
      4'h8: return c && !z;       4'h9: return !c || z;
      4'hA: return n == v;        4'hB: return n != v;
      4'hC: return !z && n == v;  4'hD: return z || n != v;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Reference ALU in plain 64-bit integer arithmetic
  function automatic void alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic [3:0] f, output logic [31:0] r, output logic [3:0] nf);
    longint ua, ub, sa, sb, u, s;
    longint ci;
    logic   c, v;
    logic [31:0] r32;
    bit     arith;
    ua = longint'({32'h0, a}); ub = longint'({32'h0, b});
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ci = f[1] ? 64'd1 : 64'd0;
    c = f[1]; v = f[0]; arith = 1'b1; u = 0; s = 0; r = 32'h0;
    case (op)
      4'h2: begin u = ua - ub;            s = sa - sb;            c = (ua >= ub); end
      4'h3: begin u = ub - ua;            s = sb - sa;            c = (ub >= ua); end
      4'h4: begin u = ua + ub;            s = sa + sb;            c = (u >= 64'h1_0000_0000); end
      4'h5: begin u = ua + ub + ci;       s = sa + sb + ci;       c = (u >= 64'h1_0000_0000); end
      4'h6: begin u = ua - ub - (1 - ci); s = sa - sb - (1 - ci); c = (ua >= ub + 1 - ci); end
      4'h7: begin u = ub - ua - (1 - ci); s = sb - sa - (1 - ci); c = (ub >= ua + 1 - ci); end
      default: arith = 1'b0;
    endcase
    if (arith) begin
      r32 = u[31:0];
      r = r32;
      v = (s != longint'($signed(r32)));
    end else begin
      case (op)
        4'h0: r = a & b;
        4'h1: r = a ^ b;
        4'h8: r = a | b;
        4'h9: r = b;
        4'hA: r = a & ~b;
        4'hB: r = ~b;
        default: r = a;
      endcase
    end
    nf = {r[31], r == 32'h0, c, v};
  endfunction

  task automatic clear_in();
    bus.ex_alu_op = 4'h0; bus.ex_a = 32'h0; bus.ex_b = 32'h0; bus.ex_sd = 32'h0;
    bus.ex_pc4 = 32'h0; bus.ex_cond = 4'hE; bus.ex_store_cc = 1'b0; bus.ex_br = 1'b0;
    bus.ex_bl = 1'b0; bus.ex_load = 1'b0; bus.ex_mem_write = 1'b0; bus.ex_mem_enable = 1'b0;
    bus.ex_rf_enable = 1'b0; bus.ex_mem_size = 2'b00; bus.ex_rd = 4'h0;
    stall = 1'b0; flush = 1'b0;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_in();
    bus.ex_alu_op = 4'($urandom_range(0, 15));
    bus.ex_a = rand_operand(); bus.ex_b = rand_operand();
    bus.ex_sd = $urandom; bus.ex_pc4 = $urandom;
    bus.ex_cond = 4'($urandom_range(0, 15));
    bus.ex_store_cc = 1'($urandom_range(0, 1));
    bus.ex_br = ($urandom_range(0, 7) == 0);
    bus.ex_bl = ($urandom_range(0, 7) == 0);
    bus.ex_load = 1'($urandom_range(0, 1)); bus.ex_mem_write = 1'($urandom_range(0, 1));
    bus.ex_mem_enable = 1'($urandom_range(0, 1)); bus.ex_rf_enable = 1'($urandom_range(0, 1));
    bus.ex_mem_size = 2'($urandom_range(0, 3)); bus.ex_rd = 4'($urandom_range(0, 15));
  endtask

  task automatic begin_cycle();
    @(negedge clk);
    clear_in();
  endtask

  // Checks the combinational branch output, then predicts the next EX/MEM state
  task automatic commit();
    logic        pass, gate;
    logic [31:0] r;
    logic [3:0]  nf;
    #1;
    pass = pass_of(bus.ex_cond, m_flags);
`ifdef EX_COND_SQUASH_EN
    gate = pass;
`else
    gate = 1'b1;
`endif
    chk("branch_taken", 76'(branch_taken), 76'((bus.ex_br || bus.ex_bl) && pass && !flush));
    alu_model(bus.ex_alu_op, bus.ex_a, bus.ex_b, m_flags, r, nf);
    if (flush) begin
      m_mem = '0;
    end else if (!stall) begin
      m_mem.result = bus.ex_bl ? bus.ex_pc4 : r;
      m_mem.sd     = bus.ex_sd;
      m_mem.rd     = bus.ex_bl ? 4'd14 : bus.ex_rd;
      m_mem.size   = bus.ex_mem_size;
      m_mem.load   = bus.ex_load && gate;
      m_mem.mw     = bus.ex_mem_write && gate;
      m_mem.me     = bus.ex_mem_enable && gate;
      m_mem.rf     = bus.ex_bl ? pass : (bus.ex_rf_enable && gate);
    end
    if (bus.ex_store_cc && pass && !stall && !flush) m_flags = nf;
    q_mem.push_back(m_mem);
    q_flags.push_back(m_flags);
  endtask

  // Monitor: every edge presents a new EX/MEM state; compare with the oldest prediction
  always @(posedge clk) begin
    #1;
    if (!reset && q_mem.size() > 0) begin
      chk("ex_mem", 76'(dut_mem()), 76'(q_mem.pop_front()));
      chk("flags", 76'(flags), 76'(q_flags.pop_front()));
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_flags"}, 76'(flags), 76'h0);
    chk({tag, "_mem"}, 76'(dut_mem()), 76'h0);
  endtask

  initial begin
    clear_in();
    m_mem = '0; m_flags = 4'h0;
    reset = 1'b1;
    #2 check_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // 0x7FFFFFFF + 1 overflows into the sign bit
    begin_cycle();
    bus.ex_alu_op = 4'h4; bus.ex_a = 32'h7FFF_FFFF; bus.ex_b = 32'h1;
    bus.ex_store_cc = 1'b1; bus.ex_rf_enable = 1'b1; bus.ex_rd = 4'h3;
    commit();
    @(posedge clk); #2;
    chk("add_ovf_result", 76'(bus.mem_result), 76'h8000_0000);
    chk("add_ovf_flags", 76'(flags), 76'b1001);

    // 5 - 5 sets Z and C, then EQ/NE branches
    begin_cycle();
    bus.ex_alu_op = 4'h2; bus.ex_a = 32'd5; bus.ex_b = 32'd5; bus.ex_store_cc = 1'b1;
    commit();
    @(posedge clk); #2;
    chk("sub_zero_flags", 76'(flags), 76'b0110);
    begin_cycle();
    bus.ex_br = 1'b1; bus.ex_cond = 4'h0;
    #1 chk("beq_taken", 76'(branch_taken), 76'h1);
    commit();
    begin_cycle();
    bus.ex_br = 1'b1; bus.ex_cond = 4'h1;
    #1 chk("bne_not_taken", 76'(branch_taken), 76'h0);
    commit();

    // Branch-with-link writes PC+4 to r14
    begin_cycle();
    bus.ex_bl = 1'b1; bus.ex_pc4 = 32'h0000_0104; bus.ex_cond = 4'hE;
    #1 chk("bl_taken", 76'(branch_taken), 76'h1);
    commit();
    @(posedge clk); #2;
    chk("bl_link", 76'({bus.mem_result, bus.mem_rd, bus.mem_rf_enable}), 76'({32'h104, 4'd14, 1'b1}));

    // Three stalled cycles with changing inputs, then stall+flush
    for (int i = 0; i < 3; i++) begin
      begin_cycle(); rand_in(); stall = 1'b1; commit();
    end
    begin_cycle(); rand_in(); stall = 1'b1; flush = 1'b1; commit();

    // Z=0, then a conditional EQ add: squashed only when the squash feature is built in
    begin_cycle();
    bus.ex_alu_op = 4'h4; bus.ex_a = 32'd1; bus.ex_b = 32'd1; bus.ex_store_cc = 1'b1;
    commit();
    begin_cycle();
    bus.ex_alu_op = 4'h4; bus.ex_a = 32'd2; bus.ex_b = 32'd3; bus.ex_cond = 4'h0;
    bus.ex_rf_enable = 1'b1; bus.ex_rd = 4'h7;
    commit();

    for (int i = 0; i < 400; i++) begin
      begin_cycle(); rand_in();
      stall = ($urandom_range(0, 6) == 0);
      flush = ($urandom_range(0, 9) == 0);
      commit();
    end

    // Asynchronous reset between edges after a flag-setting op
    begin_cycle();
    bus.ex_alu_op = 4'h2; bus.ex_a = 32'd1; bus.ex_b = 32'd2; bus.ex_store_cc = 1'b1;
    bus.ex_rf_enable = 1'b1; bus.ex_rd = 4'h9; bus.ex_sd = 32'hDEAD_BEEF;
    commit();
    @(posedge clk); #2;
    reset = 1'b1;
    #1 check_zero("async_reset");
    reset = 1'b0;
    m_mem = '0; m_flags = 4'h0;
    q_mem.delete(); q_flags.delete();

    for (int i = 0; i < 60; i++) begin
      begin_cycle(); rand_in();
      stall = ($urandom_range(0, 6) == 0);
      flush = ($urandom_range(0, 9) == 0);
      commit();
    end

    begin_cycle();
    repeat (3) @(posedge clk);
    #3;
    chk("scoreboard_drained", 76'(q_mem.size()), 76'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
